// File: rtl/store_forward_queue.sv
// LSU store queue: holds stores from dispatch to cache drain, tracks per-entry
// alloc/ready/commit state and forwards store bytes to younger-than-marker loads.
module store_forward_queue #(
    parameter  int DEPTH     = 8,
    parameter  int XLEN      = 32,
    parameter  int ROB_IDX_W = 5,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int PTR_W     = IDX_W + 1,
    localparam int BE_W      = XLEN / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 alloc_vld_i,
    input  logic [ROB_IDX_W-1:0] alloc_rob_idx_i,
    output logic [IDX_W-1:0]     alloc_idx_o,
    output logic [PTR_W-1:0]     alloc_ptr_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [PTR_W-1:0]     count_o,
    input  logic                 exec_vld_i,
    input  logic [IDX_W-1:0]     exec_idx_i,
    input  logic [XLEN-1:0]      exec_addr_i,
    input  logic [XLEN-1:0]      exec_data_i,
    input  logic [1:0]           exec_size_i,
    input  logic                 cmit_vld_i,
    output logic                 drain_vld_o,
    input  logic                 drain_rdy_i,
    output logic [XLEN-1:0]      drain_addr_o,
    output logic [XLEN-1:0]      drain_data_o,
    output logic [BE_W-1:0]      drain_be_o,
    input  logic                 ld_vld_i,
    input  logic [XLEN-1:0]      ld_addr_i,
    input  logic [1:0]           ld_size_i,
    input  logic [PTR_W-1:0]     ld_marker_i,
    output logic                 ld_resp_vld_o,
    output logic                 ld_hit_o,
    output logic                 ld_conflict_o,
    output logic [XLEN-1:0]      ld_data_o
);

    localparam int OFF_W = $clog2(BE_W);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

    typedef enum logic [1:0] {E_FREE, E_ALLOC, E_READY, E_CMIT} entry_state_t;

    entry_state_t    state_q [DEPTH];
    logic [XLEN-1:0] addr_q  [DEPTH];
    logic [XLEN-1:0] data_q  [DEPTH];
    logic [BE_W-1:0] be_q    [DEPTH];
    logic [PTR_W-1:0] head_q, cmit_q, tail_q;

    function automatic logic [BE_W-1:0] size_mask(input logic [1:0] size);
        logic [BE_W-1:0] m;
        for (int b = 0; b < BE_W; b++) m[b] = (b < (1 << size));
        return m;
    endfunction

    function automatic logic [XLEN-1:0] byte_expand(input logic [BE_W-1:0] m);
        logic [XLEN-1:0] e;
        for (int b = 0; b < BE_W; b++) e[8*b +: 8] = {8{m[b]}};
        return e;
    endfunction

    logic [IDX_W-1:0] head_idx, cmit_idx, tail_idx;
    assign head_idx = head_q[IDX_W-1:0];
    assign cmit_idx = cmit_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    assign count_o     = tail_q - head_q;
    assign full_o      = (count_o == PTR_DEPTH);
    assign empty_o     = (tail_q == head_q);
    assign alloc_idx_o = tail_idx;
    assign alloc_ptr_o = tail_q;

    // Drain handshake: drain_vld_o stays high with stable addr/data/be until the
    // cycle drain_rdy_i is also high; that cycle transfers the head and frees it.
    assign drain_vld_o  = (state_q[head_idx] == E_CMIT);
    assign drain_addr_o = drain_vld_o ? addr_q[head_idx] : '0;
    assign drain_data_o = drain_vld_o ? data_q[head_idx] : '0;
    assign drain_be_o   = drain_vld_o ? be_q[head_idx] : '0;

    logic drain_fire, cmit_fire, alloc_fire, exec_fire;
    assign drain_fire = drain_vld_o && drain_rdy_i;
    assign cmit_fire  = cmit_vld_i && (cmit_q != tail_q) && (state_q[cmit_idx] == E_READY);
    assign alloc_fire = alloc_vld_i && !full_o && !flush_i;
    assign exec_fire  = exec_vld_i && !flush_i && (state_q[exec_idx_i] == E_ALLOC);

    logic [OFF_W-1:0] exec_off;
    logic [XLEN-1:0]  exec_word, exec_lane;
    logic [BE_W-1:0]  exec_be;
    assign exec_off  = exec_addr_i[OFF_W-1:0];
    assign exec_word = {exec_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign exec_be   = size_mask(exec_size_i) << exec_off;
    assign exec_lane = (exec_data_i & byte_expand(size_mask(exec_size_i))) << {exec_off, 3'b000};

    logic [OFF_W-1:0] ld_off;
    logic [XLEN-1:0]  ld_word;
    logic [BE_W-1:0]  ld_be;
    assign ld_off  = ld_addr_i[OFF_W-1:0];
    assign ld_word = {ld_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign ld_be   = size_mask(ld_size_i) << ld_off;

    logic [PTR_W-1:0] srch_dist, srch_ptr;
    logic [IDX_W-1:0] srch_idx;
    logic             srch_alloc, srch_found, srch_cover, srch_hit, srch_conf;
    logic [XLEN-1:0]  srch_data;

    // Walk youngest-first from the marker back to head; a marker more than DEPTH
    // ahead of head is stale (its stores already drained) and searches nothing.
    always_comb begin
        srch_dist  = ld_marker_i - head_q;
        srch_ptr   = '0;
        srch_idx   = '0;
        srch_alloc = 1'b0;
        srch_found = 1'b0;
        srch_cover = 1'b0;
        srch_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            srch_ptr = ld_marker_i - PTR_W'(k + 1);
            srch_idx = srch_ptr[IDX_W-1:0];
            if (srch_dist <= PTR_DEPTH && PTR_W'(k) < srch_dist) begin
                if (state_q[srch_idx] == E_ALLOC) begin
                    srch_alloc = 1'b1;
                end else if (!srch_found && (state_q[srch_idx] == E_READY || state_q[srch_idx] == E_CMIT)
                             && addr_q[srch_idx] == ld_word && (be_q[srch_idx] & ld_be) != '0) begin
                    srch_found = 1'b1;
                    srch_cover = ((be_q[srch_idx] & ld_be) == ld_be);
                    srch_data  = (data_q[srch_idx] >> {ld_off, 3'b000}) & byte_expand(size_mask(ld_size_i));
                end
            end
        end
        srch_hit  = !srch_alloc && srch_found && srch_cover;
        srch_conf = srch_alloc || (srch_found && !srch_cover);
    end

    logic unused_ok;
    assign unused_ok = ^alloc_rob_idx_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            head_q        <= '0;
            cmit_q        <= '0;
            tail_q        <= '0;
            ld_resp_vld_o <= 1'b0;
            ld_hit_o      <= 1'b0;
            ld_conflict_o <= 1'b0;
            ld_data_o     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= E_FREE;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                be_q[i]    <= '0;
            end
        end else begin
            if (drain_fire) head_q <= head_q + PTR_ONE;
            if (cmit_fire)  cmit_q <= cmit_q + PTR_ONE;
            if (flush_i)
                tail_q <= cmit_fire ? cmit_q + PTR_ONE : cmit_q;
            else if (alloc_fire)
                tail_q <= tail_q + PTR_ONE;

            // Later assignments win: a flush overrides alloc/exec on the same slot,
            // but never touches the entry committed this cycle.
            for (int i = 0; i < DEPTH; i++) begin
                if (drain_fire && head_idx == IDX_W'(i)) state_q[i] <= E_FREE;
                if (alloc_fire && tail_idx == IDX_W'(i)) state_q[i] <= E_ALLOC;
                if (exec_fire && exec_idx_i == IDX_W'(i)) begin
                    state_q[i] <= E_READY;
                    addr_q[i]  <= exec_word;
                    data_q[i]  <= exec_lane;
                    be_q[i]    <= exec_be;
                end
                if (cmit_fire && cmit_idx == IDX_W'(i)) state_q[i] <= E_CMIT;
                if (flush_i && (state_q[i] == E_ALLOC || state_q[i] == E_READY)
                    && !(cmit_fire && cmit_idx == IDX_W'(i)))
                    state_q[i] <= E_FREE;
            end

            ld_resp_vld_o <= ld_vld_i && !flush_i;
            ld_hit_o      <= ld_vld_i && !flush_i && srch_hit;
            ld_conflict_o <= ld_vld_i && !flush_i && srch_conf;
            ld_data_o     <= (ld_vld_i && !flush_i && srch_hit) ? srch_data : '0;
        end
    end

endmodule

// File: tb/tb_store_forward_queue.sv
// Bench for store_forward_queue: directed scenarios plus a randomized run, all
// checked against a byte-level list model of the store queue.
module tb_store_forward_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 4;

    logic        clk, rst, flush, alloc_vld, exec_vld, cmit_vld, drain_rdy, ld_vld;
    logic [4:0]  alloc_rob_idx;
    logic [2:0]  alloc_idx, exec_idx;
    logic [3:0]  alloc_ptr, count, ld_marker, drain_be;
    logic        full, empty, drain_vld, ld_resp_vld, ld_hit, ld_conflict;
    logic [31:0] exec_addr, exec_data, drain_addr, drain_data, ld_addr, ld_data;
    logic [1:0]  exec_size, ld_size;

    store_forward_queue dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .alloc_vld_i(alloc_vld), .alloc_rob_idx_i(alloc_rob_idx),
        .alloc_idx_o(alloc_idx), .alloc_ptr_o(alloc_ptr),
        .full_o(full), .empty_o(empty), .count_o(count),
        .exec_vld_i(exec_vld), .exec_idx_i(exec_idx), .exec_addr_i(exec_addr),
        .exec_data_i(exec_data), .exec_size_i(exec_size),
        .cmit_vld_i(cmit_vld),
        .drain_vld_o(drain_vld), .drain_rdy_i(drain_rdy), .drain_addr_o(drain_addr),
        .drain_data_o(drain_data), .drain_be_o(drain_be),
        .ld_vld_i(ld_vld), .ld_addr_i(ld_addr), .ld_size_i(ld_size), .ld_marker_i(ld_marker),
        .ld_resp_vld_o(ld_resp_vld), .ld_hit_o(ld_hit), .ld_conflict_o(ld_conflict),
        .ld_data_o(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: list of stores from head to tail; st 0=alloc, 1=ready, 2=committed.
    typedef struct { logic [31:0] addr; int size; logic [31:0] data; int st; } st_rec_t;
    st_rec_t     mq[$];
    logic [31:0] exp_q[$];
    int          mhead, mcmit, mtail, ld_marker_abs;
    int          n_checks, n_pass;
    bit          exp_resp, exp_hit, exp_conf;
    logic [31:0] exp_ldata;

    function automatic void model_reset();
        mq.delete(); exp_q.delete();
        mhead = 0; mcmit = 0; mtail = 0;
        exp_resp = 0; exp_hit = 0; exp_conf = 0; exp_ldata = '0;
    endfunction

    function automatic void lane_of(input st_rec_t r, output logic [31:0] wa,
                                    output logic [3:0] be, output logic [31:0] wd);
        int rel;
        wa = {r.addr[31:2], 2'b00}; be = '0; wd = '0;
        for (int b = 0; b < 4; b++) begin
            rel = int'(wa) + b - int'(r.addr);
            if (rel >= 0 && rel < (1 << r.size)) begin
                be[b] = 1'b1;
                wd[8*b +: 8] = r.data[8*rel +: 8];
            end
        end
    endfunction

    function automatic void model_fwd(input logic [31:0] la, input int lsz, input int marker,
                                      output bit hit, output bit conf, output logic [31:0] d);
        int  last, sel, ln, rel;
        bit  any_alloc, ovl, cov;
        ln = 1 << lsz; hit = 0; conf = 0; d = '0; any_alloc = 0; sel = -1;
        last = marker - mhead;
        if (last > mq.size()) last = mq.size();
        for (int i = last - 1; i >= 0; i--) begin
            if (mq[i].st == 0) any_alloc = 1;
            else if (sel < 0) begin
                ovl = 0;
                for (int b = 0; b < ln; b++) begin
                    rel = int'(la) + b - int'(mq[i].addr);
                    if (rel >= 0 && rel < (1 << mq[i].size)) ovl = 1;
                end
                if (ovl) sel = i;
            end
        end
        if (any_alloc) conf = 1;
        else if (sel >= 0) begin
            cov = 1;
            for (int b = 0; b < ln; b++) begin
                rel = int'(la) + b - int'(mq[sel].addr);
                if (rel >= 0 && rel < (1 << mq[sel].size)) d[8*b +: 8] = mq[sel].data[8*rel +: 8];
                else cov = 0;
            end
            if (cov) hit = 1; else begin conf = 1; d = '0; end
        end
    endfunction

    // Advance model and DUT by one clock using the currently driven inputs.
    task automatic cycle();
        bit h, c, dfire; logic [31:0] d, wa, wd; logic [3:0] wb; int pos; st_rec_t r;
        h = 0; c = 0; d = '0;
        if (ld_vld && !flush) model_fwd(ld_addr, int'(ld_size), ld_marker_abs, h, c, d);
        exp_resp = ld_vld && !flush; exp_hit = h; exp_conf = c; exp_ldata = d;
        dfire = (mq.size() > 0) && (mq[0].st == 2) && drain_rdy;
        if (cmit_vld) begin
            pos = mcmit - mhead;
            n_checks++;
            if (pos < mq.size() && mq[pos].st == 1) begin
                n_pass++; mq[pos].st = 2; mcmit++;
                lane_of(mq[pos], wa, wb, wd); exp_q.push_back(wd);
            end else $display("FAIL cmit_legal entry %0d committed while not ready", mcmit);
        end
        if (exec_vld && !flush)
            foreach (mq[i])
                if (mq[i].st == 0 && ((mhead + i) & 7) == int'(exec_idx)) begin
                    mq[i].addr = exec_addr; mq[i].size = int'(exec_size);
                    mq[i].data = exec_data; mq[i].st = 1;
                end
        if (alloc_vld && !flush && mq.size() < DEPTH) begin
            r.addr = '0; r.size = 0; r.data = '0; r.st = 0;
            mq.push_back(r); mtail++;
        end
        if (flush) begin
            while (mq.size() > mcmit - mhead) void'(mq.pop_back());
            mtail = mcmit;
        end
        if (dfire) begin void'(mq.pop_front()); void'(exp_q.pop_front()); mhead++; end
        @(posedge clk); #1;
        alloc_vld = 0; exec_vld = 0; cmit_vld = 0; ld_vld = 0; flush = 0;
    endtask

    task automatic store_op(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] dat);
        alloc_vld = 1; alloc_rob_idx = 5'($urandom_range(0, 31)); cycle();
        exec_vld = 1; exec_idx = 3'((mtail - 1) & 7); exec_addr = a; exec_size = sz; exec_data = dat;
        cycle();
    endtask

    task automatic set_load(input logic [31:0] a, input logic [1:0] sz, input int marker);
        ld_vld = 1; ld_addr = a; ld_size = sz; ld_marker_abs = marker; ld_marker = PTR_W'(marker);
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL rst_full got %b want 0", full); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL rst_count got %0d want 0", count); else n_pass++;
        n_checks++; if (drain_vld !== 1'b0) $display("FAIL rst_drain_vld got %b want 0", drain_vld); else n_pass++;
        n_checks++; if ({drain_addr, drain_data, drain_be} !== 68'd0)
            $display("FAIL rst_drain_bus got %h/%h/%h want 0", drain_addr, drain_data, drain_be); else n_pass++;
        n_checks++; if ({ld_resp_vld, ld_hit, ld_conflict, ld_data} !== 35'd0)
            $display("FAIL rst_ld got %b%b%b %h want 0", ld_resp_vld, ld_hit, ld_conflict, ld_data); else n_pass++;
        n_checks++; if ({alloc_idx, alloc_ptr} !== 7'd0)
            $display("FAIL rst_alloc got %0d/%0d want 0", alloc_idx, alloc_ptr); else n_pass++;
        rst = 1;
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin alloc_vld = 1; cycle(); end
        n_checks++; if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full); else n_pass++;
        n_checks++; if (count !== 4'd8) $display("FAIL full_count got %0d want 8", count); else n_pass++;
        alloc_vld = 1; cycle();
        n_checks++; if (count !== 4'd8 || alloc_ptr !== 4'd8)
            $display("FAIL full_ignore got count %0d ptr %0d want 8 8", count, alloc_ptr); else n_pass++;
        exec_vld = 1; exec_idx = 3'd0; exec_addr = 32'h40; exec_size = 2'd2; exec_data = $urandom; cycle();
        cmit_vld = 1; cycle();
        drain_rdy = 1; cycle(); drain_rdy = 0;
        n_checks++; if (full !== 1'b0 || count !== 4'd7)
            $display("FAIL full_after_drain got full %b count %0d want 0 7", full, count); else n_pass++;
        flush = 1; cycle();
        n_checks++; if (empty !== 1'b1 || count !== 4'(mtail - mhead))
            $display("FAIL full_flush got empty %b count %0d want 1 0", empty, count); else n_pass++;
    endtask

    task automatic test_drain_hold();
        store_op(32'h100, 2'd2, 32'hAABBCCDD);
        cmit_vld = 1; drain_rdy = 0; cycle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (drain_vld !== 1'b1 || drain_addr !== 32'h100 || drain_be !== 4'hF || drain_data !== 32'hAABBCCDD)
                $display("FAIL drain_hold cyc %0d got %b %h %h %h want 1 100 f aabbccdd",
                         i, drain_vld, drain_addr, drain_be, drain_data);
            else n_pass++;
            cycle();
        end
        drain_rdy = 1; cycle(); drain_rdy = 0;
        n_checks++; if (empty !== 1'b1 || drain_vld !== 1'b0)
            $display("FAIL drain_done got empty %b vld %b want 1 0", empty, drain_vld); else n_pass++;
    endtask

    task automatic test_fwd_byte();
        store_op(32'h103, 2'd0, 32'h5A);
        set_load(32'h103, 2'd0, mtail); cycle();
        n_checks++; if (ld_resp_vld !== 1'b1 || ld_hit !== 1'b1 || ld_conflict !== 1'b0 || ld_data !== 32'h5A)
            $display("FAIL fwd_lb got %b%b%b %h want 110 5a", ld_resp_vld, ld_hit, ld_conflict, ld_data); else n_pass++;
        set_load(32'h100, 2'd2, mtail); cycle();
        n_checks++; if (ld_hit !== 1'b0 || ld_conflict !== 1'b1)
            $display("FAIL fwd_lw_partial got hit %b conf %b want 0 1", ld_hit, ld_conflict); else n_pass++;
        n_checks++; if (ld_conflict !== exp_conf) $display("FAIL fwd_model got %b want %b", ld_conflict, exp_conf); else n_pass++;
        cycle();
        n_checks++; if (ld_resp_vld !== 1'b0) $display("FAIL fwd_pulse got %b want 0", ld_resp_vld); else n_pass++;
        flush = 1; cycle();
    endtask

    task automatic test_youngest();
        store_op(32'h200, 2'd2, 32'h11223344);
        store_op(32'h202, 2'd1, 32'hBEEF);
        set_load(32'h200, 2'd2, mtail); cycle();
        n_checks++; if (ld_conflict !== 1'b1 || ld_hit !== 1'b0)
            $display("FAIL young_lw got hit %b conf %b want 0 1", ld_hit, ld_conflict); else n_pass++;
        set_load(32'h202, 2'd1, mtail); cycle();
        n_checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hBEEF)
            $display("FAIL young_lh_hi got hit %b data %h want 1 beef", ld_hit, ld_data); else n_pass++;
        set_load(32'h200, 2'd1, mtail); cycle();
        n_checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h3344)
            $display("FAIL young_lh_lo got hit %b data %h want 1 3344", ld_hit, ld_data); else n_pass++;
        flush = 1; cycle();
    endtask

    task automatic test_flush();
        int old_marker;
        store_op(32'h400, 2'd2, 32'h01020304);
        store_op(32'h404, 2'd2, 32'h05060708);
        store_op(32'h408, 2'd2, 32'h090A0B0C);
        cmit_vld = 1; cycle();
        old_marker = mtail;
        flush = 1; cycle();
        n_checks++; if (count !== 4'd1 || alloc_ptr !== PTR_W'(mcmit))
            $display("FAIL flush_count got %0d ptr %0d want 1 %0d", count, alloc_ptr, PTR_W'(mcmit)); else n_pass++;
        set_load(32'h404, 2'd2, old_marker); cycle();
        n_checks++; if (ld_hit !== 1'b0 || ld_conflict !== 1'b0)
            $display("FAIL flush_stale got hit %b conf %b want 0 0", ld_hit, ld_conflict); else n_pass++;
        set_load(32'h400, 2'd2, old_marker); cycle();
        n_checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h01020304)
            $display("FAIL flush_cmit_fwd got hit %b data %h want 1 01020304", ld_hit, ld_data); else n_pass++;
        n_checks++; if (drain_vld !== 1'b1 || drain_addr !== 32'h400)
            $display("FAIL flush_drain got vld %b addr %h want 1 400", drain_vld, drain_addr); else n_pass++;
        drain_rdy = 1; cycle(); drain_rdy = 0;
        n_checks++; if (empty !== 1'b1) $display("FAIL flush_empty got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_simul();
        store_op(32'h700, 2'd2, 32'hCAFEF00D);
        alloc_vld = 1; cycle();
        cmit_vld = 1; flush = 1; alloc_vld = 1;
        exec_vld = 1; exec_idx = 3'((mtail - 1) & 7); exec_addr = 32'h704; exec_size = 2'd2; exec_data = 32'h1;
        set_load(32'h700, 2'd2, mtail); cycle();
        n_checks++; if (ld_resp_vld !== 1'b0) $display("FAIL simul_ld_supp got %b want 0", ld_resp_vld); else n_pass++;
        n_checks++; if (count !== 4'd1 || alloc_ptr !== PTR_W'(mcmit))
            $display("FAIL simul_cmit_flush got count %0d ptr %0d want 1 %0d", count, alloc_ptr, PTR_W'(mcmit)); else n_pass++;
        n_checks++; if (drain_vld !== 1'b1 || drain_data !== 32'hCAFEF00D)
            $display("FAIL simul_drain got %b %h want 1 cafef00d", drain_vld, drain_data); else n_pass++;
        drain_rdy = 1; flush = 1; cycle(); drain_rdy = 0;
        n_checks++; if (empty !== 1'b1) $display("FAIL simul_drain_flush got empty %b want 1", empty); else n_pass++;
    endtask

    task automatic test_wrap();
        int old_marker; logic [31:0] v;
        for (int r = 0; r < 20; r++) begin
            store_op(32'h500 + 32'(4 * (r % 4)), 2'd2, $urandom);
            cmit_vld = 1; cycle();
            drain_rdy = 1; cycle(); drain_rdy = 0;
            n_checks++; if (alloc_ptr !== PTR_W'(mtail) || empty !== 1'b1)
                $display("FAIL wrap_ptr r %0d got %0d empty %b want %0d 1", r, alloc_ptr, empty, PTR_W'(mtail)); else n_pass++;
        end
        old_marker = mtail;
        v = $urandom;
        store_op(32'h600, 2'd2, v);
        set_load(32'h600, 2'd2, old_marker); cycle();
        n_checks++; if (ld_hit !== 1'b0 || ld_conflict !== 1'b0)
            $display("FAIL wrap_older got hit %b conf %b want 0 0", ld_hit, ld_conflict); else n_pass++;
        set_load(32'h600, 2'd2, mtail); cycle();
        n_checks++; if (ld_hit !== 1'b1 || ld_data !== v)
            $display("FAIL wrap_younger got hit %b data %h want 1 %h", ld_hit, ld_data, v); else n_pass++;
        flush = 1; cycle();
    endtask

    task automatic test_random();
        int cand[$]; int pick, n; logic [31:0] wa, wd; logic [3:0] wb;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++; if (count !== 4'(mtail - mhead) || empty !== (mtail == mhead) || full !== (mtail - mhead == DEPTH))
                $display("FAIL rnd_occ cyc %0d got %0d %b %b want %0d", cyc, count, empty, full, mtail - mhead); else n_pass++;
            n_checks++; if (drain_vld !== (mq.size() > 0 && mq[0].st == 2))
                $display("FAIL rnd_drain_vld cyc %0d got %b", cyc, drain_vld); else n_pass++;
            if (mq.size() > 0 && mq[0].st == 2 && exp_q.size() > 0) begin
                lane_of(mq[0], wa, wb, wd);
                n_checks++; if (drain_data !== exp_q[0] || drain_addr !== wa || drain_be !== wb)
                    $display("FAIL rnd_drain cyc %0d got %h %h %h want %h %h %h", cyc, drain_addr, drain_be, drain_data, wa, wb, exp_q[0]);
                else n_pass++;
            end
            n_checks++; if (ld_resp_vld !== exp_resp || ld_hit !== exp_hit || ld_conflict !== exp_conf)
                $display("FAIL rnd_ld cyc %0d got %b%b%b want %b%b%b", cyc, ld_resp_vld, ld_hit, ld_conflict, exp_resp, exp_hit, exp_conf);
            else n_pass++;
            if (exp_hit) begin
                n_checks++; if (ld_data !== exp_ldata) $display("FAIL rnd_ld_data cyc %0d got %h want %h", cyc, ld_data, exp_ldata); else n_pass++;
            end
            alloc_vld = ($urandom_range(0, 99) < 50);
            cand.delete();
            foreach (mq[i]) if (mq[i].st == 0) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 99) < 60) begin
                pick = cand[$urandom_range(0, cand.size() - 1)];
                exec_size = 2'($urandom_range(0, 2)); n = 1 << exec_size;
                exec_vld = 1; exec_idx = 3'((mhead + pick) & 7); exec_data = $urandom;
                exec_addr = 32'h300 + (32'($urandom_range(0, 15)) & ~32'(n - 1));
            end
            if (mcmit < mtail && mq[mcmit - mhead].st == 1 && $urandom_range(0, 99) < 50) cmit_vld = 1;
            drain_rdy = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 50) begin
                ld_size = 2'($urandom_range(0, 2)); n = 1 << ld_size;
                set_load(32'h300 + (32'($urandom_range(0, 15)) & ~32'(n - 1)), ld_size, $urandom_range(mhead, mtail));
            end
            flush = ($urandom_range(0, 99) < 4);
            cycle();
        end
        drain_rdy = 0;
    endtask

    task automatic test_reset_mid_drain();
        store_op(32'h800, 2'd2, 32'h12345678);
        cmit_vld = 1; cycle();
        n_checks++; if (drain_vld !== 1'b1) $display("FAIL mid_drain_pre got %b want 1", drain_vld); else n_pass++;
        rst = 0; @(posedge clk); #1; rst = 1;
        model_reset();
        n_checks++; if (drain_vld !== 1'b0 || empty !== 1'b1 || count !== 4'd0)
            $display("FAIL mid_drain_rst got vld %b empty %b count %0d want 0 1 0", drain_vld, empty, count); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; ld_marker_abs = 0;
        rst = 0; flush = 0; alloc_vld = 0; alloc_rob_idx = '0; exec_vld = 0; exec_idx = '0;
        exec_addr = '0; exec_data = '0; exec_size = '0; cmit_vld = 0; drain_rdy = 0;
        ld_vld = 0; ld_addr = '0; ld_size = '0; ld_marker = '0;
        model_reset();
        test_reset();
        test_full();
        test_drain_hold();
        test_fwd_byte();
        test_youngest();
        test_flush();
        test_simul();
        test_wrap();
        test_random();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_forward_queue.md
# store_forward_queue

Parametrised store queue for the LSU that holds stores from dispatch until drain to the cache controller. Each entry is tracked as allocated, address-ready or committed, with per-byte enables for SB/SH/SW/SD. A flush discards only speculative (uncommitted) entries; committed entries keep draining. Loads get byte-accurate store-to-load forwarding with hit/conflict reporting.

## Interface
- DEPTH, 8, entries; power of two, ≥2
- XLEN, 32, data/address width; 32 or 64
- ROB_IDX_W, 5, ROB index width
- IDX_W = $clog2(DEPTH) (derived); PTR_W = IDX_W+1 (derived, includes wrap bit); BE_W = XLEN/8 (derived)

- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- flush_i  in  1  discard all uncommitted entries
- alloc_vld_i  in  1  allocate entry at tail (dispatch)
- alloc_rob_idx_i  in  ROB_IDX_W  owning ROB index
- alloc_idx_o  out  IDX_W  tail slot index
- alloc_ptr_o  out  PTR_W  tail pointer; load dispatch saves it as its marker
- full_o  out  1  no free entry
- empty_o  out  1  no entries
- count_o  out  PTR_W  occupied entries
- exec_vld_i  in  1  address/data ready
- exec_idx_i  in  IDX_W  target entry
- exec_addr_i  in  XLEN  byte address, naturally aligned
- exec_data_i  in  XLEN  store data, right-justified
- exec_size_i  in  2  00 B, 01 H, 10 W, 11 D (XLEN=64 only)
- cmit_vld_i  in  1  ROB commits the oldest uncommitted store
- drain_vld_o  out  1  head entry committed, ready to write
- drain_rdy_i  in  1  cache controller accepts
- drain_addr_o  out  XLEN  XLEN/8-aligned address
- drain_data_o  out  XLEN  data shifted to byte lanes
- drain_be_o  out  BE_W  byte enables
- ld_vld_i  in  1  forwarding lookup
- ld_addr_i  in  XLEN  load address
- ld_size_i  in  2  load size
- ld_marker_i  in  PTR_W  tail pointer captured at load dispatch
- ld_resp_vld_o  out  1  lookup result valid
- ld_hit_o  out  1  fully forwarded
- ld_conflict_o  out  1  load must replay
- ld_data_o  out  XLEN  forwarded data, right-justified, zero-extended

## Operation
- Pointers: head (drain), cmit (first uncommitted), tail (alloc). All are PTR_W wide; the MSB is the wrap bit. Invariant: head ≤ cmit ≤ tail in queue order.
- Entry states: FREE → ALLOC (on alloc) → READY (on exec: address, lane-shifted data and BE latched) → CMIT (on cmit) → FREE (on drain handshake).
- Full: tail-head == DEPTH. Empty: tail == head.
- Commit advances cmit by one. Committing an entry that is not READY is illegal; the bench asserts on it.
- Drain: drain_vld_o = head entry in CMIT. Outputs come from head registers and stay stable until drain_rdy_i. Head advances on vld&&rdy.
- Flush: tail ← cmit. Uncommitted entries go to FREE.
- Forward search covers entries in [head, ld_marker_i), ordered youngest first:
  - Any entry in ALLOC state → conflict.
  - Otherwise take the youngest entry whose BE overlaps the load bytes within the same aligned word:
    - Covers every load byte → hit; data = the selected bytes, right-justified.
    - Partial overlap → conflict.
  - No overlap → hit=0, conflict=0 (load reads the cache).
- Misaligned addresses are illegal.

## Timing
- Reset (rst_i low at a clock edge): all pointers 0, entries FREE. Outputs: full_o=0, empty_o=1, count_o=0, drain_vld_o=0, ld_resp_vld_o=0, ld_hit_o=0, ld_conflict_o=0, ld_data_o=0, drain_*/alloc_idx_o/alloc_ptr_o=0. Reset mid-drain abandons the transfer.
- Alloc/exec/cmit take effect at the clock edge; the state is visible the next cycle.
- alloc while full_o=1 is ignored. A same-cycle drain does not free a slot for that cycle's alloc.
- Lookup latency is 1 cycle: ld_resp_vld_o pulses the cycle after ld_vld_i. The search uses pre-edge state, so an exec in the same cycle is not seen. If flush_i is high in the lookup cycle, the response is suppressed.
- Simultaneous events:
  - cmit+flush: the commit applies first and its entry survives.
  - alloc+flush: alloc is dropped.
  - exec+flush on an uncommitted entry: dropped.
  - drain+flush: drain proceeds.
- Wrap-around: pointers wrap at DEPTH with the wrap bit toggling. Marker comparison is modular.

## Test plan
- Reset, then 8 allocs with DEPTH=8 → full_o=1 and count_o=8; 9th alloc ignored; drain one entry → full_o=0 next cycle.
- SW 0x100 data 0xAABBCCDD, exec, commit, drain_rdy_i=0 for 3 cycles → drain_vld_o held with addr 0x100, BE 4'b1111, data stable; rdy=1 → empty_o=1 next cycle.
- SB 0x103 data 0x5A, then LB 0x103 → hit=1, ld_data_o=0x5A. Then LW 0x100 → conflict=1.
- SW 0x200 =0x11223344 followed by SH 0x202 =0xBEEF, then LW 0x200 → conflict. LH 0x202 → hit, data 0xBEEF (youngest). LH 0x200 → hit, data 0x3344.
- 3 stores with 1 committed, then flush → count_o=1, tail=cmit; the committed store still drains. A load with a marker past the flushed entries → no hit.
- Run 20 alloc/drain cycles to force pointer wrap; a load whose marker precedes a younger store → the younger store is ignored and no hit occurs.
